// File: rtl/word_packer_pkg.sv
// ---------------------------------------------------------------------------
// word_packer_pkg
//   Shared constants and types for the word_packer serial-to-parallel stage.
//   WORD_W   : bits per input word / output slot
//   N_WORDS  : words per packed frame
//   CNT_W    : slot counter width
//   FRAME_W  : packed frame width (WORD_W * N_WORDS)
//   N_COPIES : number of redundant copies of every state register
// ---------------------------------------------------------------------------
package word_packer_pkg;

   localparam int WORD_W   = 10;
   localparam int N_WORDS  = 48;
   localparam int CNT_W    = $clog2(N_WORDS);
   localparam int FRAME_W  = WORD_W * N_WORDS;
   localparam int N_COPIES = 3;

   typedef enum logic [1:0] {
      WP_INIT = 2'd0,
      WP_FILL = 2'd1,
      WP_FULL = 2'd2
   } wp_state_t;

endpackage

// File: rtl/word_packer.sv
// ---------------------------------------------------------------------------
// word_packer
//   Collects N_WORDS words from a valid/ready input stream into one packed
//   frame and presents it on a valid/ready output. Word k of a frame lands
//   in out_data[k*WORD_W +: WORD_W]. The fill buffer drives out_data
//   directly, so slot contents are only meaningful while out_valid=1.
//
//   All state (FSM, slot counter, fill buffer) is held in three copies and
//   majority-voted; next-state logic works on the voted values and writes
//   the same result back into every copy, so a single upset is scrubbed on
//   the following edge.
//
// Ports
//   clk         in   1        single clock, rising edge
//   rst         in   1        asynchronous active-high reset
//   clear       in   1        synchronous frame abort (ignored in INIT)
//   in_valid    in   1        input word valid
//   in_ready    out  1        block accepts a word this cycle (state==FILL)
//   in_data     in   WORD_W   input word
//   out_valid   out  1        packed frame valid (state==FULL)
//   out_ready   in   1        downstream accepts the frame
//   out_data    out  FRAME_W  packed frame
//   word_cnt    out  CNT_W    slots filled in the current frame
//   o_dbg_state out  2        voted FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. valid/data are held stable until that edge; ready never depends
// combinationally on the opposite side's valid or ready.
// ---------------------------------------------------------------------------
module word_packer
   import word_packer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORD_W-1:0]   in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [FRAME_W-1:0]  out_data,
   output logic [CNT_W-1:0]    word_cnt,
   output wp_state_t           o_dbg_state
);

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_WORDS - 1);

   // Redundant state copies.
   logic [1:0]          r_state [N_COPIES];
   logic [CNT_W-1:0]    r_cnt   [N_COPIES];
   logic [FRAME_W-1:0]  r_buf   [N_COPIES];

   // Voted state and next-state.
   wp_state_t           w_state;
   logic [CNT_W-1:0]    w_cnt;
   logic [FRAME_W-1:0]  w_buf;
   wp_state_t           w_state_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [FRAME_W-1:0]  w_buf_nxt;

   // Bitwise 2-of-3 majority.
   assign w_state = wp_state_t'((r_state[0] & r_state[1]) |
                                (r_state[0] & r_state[2]) |
                                (r_state[1] & r_state[2]));
   assign w_cnt   = (r_cnt[0] & r_cnt[1]) |
                    (r_cnt[0] & r_cnt[2]) |
                    (r_cnt[1] & r_cnt[2]);
   assign w_buf   = (r_buf[0] & r_buf[1]) |
                    (r_buf[0] & r_buf[2]) |
                    (r_buf[1] & r_buf[2]);

   // State register: every copy loads the same voted next value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_COPIES; i++) begin
            r_state[i] <= WP_INIT;
            r_cnt[i]   <= '0;
            r_buf[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_COPIES; i++) begin
            r_state[i] <= w_state_nxt;
            r_cnt[i]   <= w_cnt_nxt;
            r_buf[i]   <= w_buf_nxt;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = w_state;
      w_cnt_nxt   = w_cnt;
      w_buf_nxt   = w_buf;
      unique case (w_state)
         WP_INIT: begin
            // clear is deliberately ignored here.
            w_state_nxt = WP_FILL;
         end
         WP_FILL: begin
            if (clear) begin
               // Word presented in the clear cycle is dropped; the buffer
               // keeps its old contents and is overwritten slot by slot.
               w_cnt_nxt = '0;
            end else if (in_valid) begin
               w_buf_nxt[w_cnt*WORD_W +: WORD_W] = in_data;
               if (w_cnt == LAST_SLOT) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = WP_FULL;
               end else begin
                  w_cnt_nxt = w_cnt + CNT_W'(1);
               end
            end
         end
         WP_FULL: begin
            if (clear) begin
               // Pending frame is discarded.
               w_cnt_nxt   = '0;
               w_state_nxt = WP_FILL;
            end else if (out_ready) begin
               w_state_nxt = WP_FILL;
            end
         end
         default: begin
            // Unused encoding after a double upset: restart cleanly.
            w_cnt_nxt   = '0;
            w_state_nxt = WP_INIT;
         end
      endcase
   end

   // Outputs decoded from registered state only.
   assign in_ready    = (w_state == WP_FILL);
   assign out_valid   = (w_state == WP_FULL);
   assign out_data    = w_buf;
   assign word_cnt    = w_cnt;
   assign o_dbg_state = w_state;

endmodule

// File: tb/tb_word_packer.sv
module tb_word_packer;
  import word_packer_pkg::*;

  // ---------------- clock / reset ----------------
  logic               clk;
  logic               rst;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [FRAME_W-1:0] out_data;
  logic [CNT_W-1:0]   word_cnt;
  wp_state_t          o_dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  word_packer dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .word_cnt    (word_cnt),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [FRAME_W-1:0] exp_q[$];
  int                 rise_q[$];
  logic [FRAME_W-1:0] model_buf;
  int                 model_cnt;
  int                 n_checks;
  int                 n_fail;
  int                 cyc;
  int                 first_acc;
  logic               prev_ov;

  task automatic chk(input string tag, input logic [FRAME_W-1:0] act,
                     input logic [FRAME_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    model_buf = '0;
    model_cnt = 0;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic drive_word(input logic [WORD_W-1:0] d);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
      return;
    end
    chk("word_cnt", word_cnt, model_cnt);
    if (model_cnt == 0) first_acc = cyc;
    model_buf[model_cnt*WORD_W +: WORD_W] = d;
    if (model_cnt == N_WORDS - 1) begin
      exp_q.push_back(model_buf);
      model_cnt = 0;
    end else begin
      model_cnt++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) tick();
    model_reset();
    exp_q.delete();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_word_cnt", word_cnt, '0);
    chk("rst_state", o_dbg_state, WP_INIT);
    rst = 1'b0;
    chk("init_in_ready", in_ready, 1'b0);
    tick();
    chk("fill_state", o_dbg_state, WP_FILL);
    chk("fill_in_ready", in_ready, 1'b1);
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) rise_q.push_back(cyc);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_frame", 1'b1, 1'b0);
        else chk("sb_frame", out_data, exp_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [FRAME_W-1:0] pat;
    logic [FRAME_W-1:0] held;
    int                 nr;
    n_checks = 0; n_fail = 0; cyc = 0; first_acc = 0; prev_ov = 1'b0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_reset();

    // 1. back-to-back frame, value = index
    do_reset();
    nr = rise_q.size();
    for (int k = 0; k < N_WORDS; k++) drive_word(WORD_W'(k));
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_slot0", out_data[9:0], 10'd0);
    chk("t1_slot47", out_data[479:470], 10'd47);
    tick();
    chk("t1_latency", (rise_q.size() > nr) ? rise_q[nr] - first_acc + 1 : -1, 49);
    chk("t1_ov_drop", out_valid, 1'b0);
    chk("t1_in_ready_back", in_ready, 1'b1);

    // 2. downstream stall for 5 cycles
    out_ready = 1'b0;
    for (int k = 0; k < N_WORDS; k++) drive_word(WORD_W'(k));
    held = (exp_q.size() > 0) ? exp_q[0] : '1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_ov_hold", out_valid, 1'b1);
      chk("t2_in_ready_low", in_ready, 1'b0);
      chk("t2_data_stable", out_data, held);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t2_released", out_valid, 1'b0);
    chk("t2_in_ready_back", in_ready, 1'b1);

    // 3. random bubbles, data 3FF-k
    for (int k = 0; k < N_WORDS; k++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = WORD_W'($urandom);
        tick();
        chk("t3_cnt_hold", word_cnt, WORD_W'(k));
      end
      drive_word(10'h3FF - WORD_W'(k));
    end
    chk("t3_slot0", out_data[9:0], 10'h3FF);
    chk("t3_slot47", out_data[479:470], 10'h3D0);
    tick();

    // 4. clear after 20 words, then 48 words of 155
    for (int k = 0; k < 20; k++) drive_word(10'h2AA);
    clear = 1'b1; in_valid = 1'b1; in_data = 10'h0AA;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    model_cnt = 0;
    chk("t4_cnt_cleared", word_cnt, '0);
    chk("t4_ov_low", out_valid, 1'b0);
    chk("t4_not_zeroed", out_data[199:190], 10'h2AA);
    for (int k = 0; k < N_WORDS; k++) begin
      chk("t4_no_early_ov", out_valid, 1'b0);
      drive_word(10'h155);
    end
    pat = {N_WORDS{10'h155}};
    chk("t4_all_155", out_data, pat);
    tick();

    // 4b. clear while a frame is pending in FULL
    out_ready = 1'b0;
    for (int k = 0; k < N_WORDS; k++) drive_word(WORD_W'(k + 300));
    chk("t4b_full", out_valid, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    chk("t4b_discarded", out_valid, 1'b0);
    chk("t4b_fill", in_ready, 1'b1);
    chk("t4b_cnt", word_cnt, '0);
    out_ready = 1'b1;

    // 5. reset mid-frame at word 30, in_valid held high
    for (int k = 0; k < 30; k++) drive_word(WORD_W'(k));
    in_valid = 1'b1; in_data = 10'd30;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5_rdy_async", in_ready, 1'b0);
    chk("t5_cnt_async", word_cnt, '0);
    chk("t5_data_async", out_data, '0);
    repeat (2) begin
      tick();
      chk("t5_rdy_in_rst", in_ready, 1'b0);
    end
    rst = 1'b0;
    clear = 1'b1;
    chk("t5_init_state", o_dbg_state, WP_INIT);
    chk("t5_init_rdy", in_ready, 1'b0);
    tick();
    clear = 1'b0;
    chk("t5_clear_in_init", o_dbg_state, WP_FILL);
    drive_word(10'h1C3);
    chk("t5_slot0", out_data[9:0], 10'h1C3);
    chk("t5_cnt1", word_cnt, 1);
    for (int k = 1; k < N_WORDS; k++) drive_word(WORD_W'(k));
    tick();

    // 6. two back-to-back frames
    nr = rise_q.size();
    for (int k = 0; k < N_WORDS; k++) drive_word(WORD_W'(k));
    for (int k = 0; k < N_WORDS; k++) drive_word(10'h200 | WORD_W'(k));
    tick();
    tick();
    chk("t6_two_pulses", rise_q.size() - nr, 2);
    chk("t6_spacing", (rise_q.size() >= nr + 2) ? rise_q[nr+1] - rise_q[nr] : -1, 49);
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
